md_unit: RTL and testbench
==========================

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits, minimum 4.
REQ-002 Parameter TAG_W, default 5: width of the destination tag carried through with each operation.
REQ-003 Port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port flush, input, 1 bit: discards the in-flight operation.
REQ-006 Port in_valid, input, 1 bit: an operation is offered.
REQ-007 Port in_ready, output, 1 bit: the unit accepts the offered operation.
REQ-008 Port op, input, 1 bit: 0 = signed multiply, 1 = signed divide.
REQ-009 Port opA, input, WIDTH bits: multiplicand or dividend, two's complement.
REQ-010 Port opB, input, WIDTH bits: multiplier or divisor, two's complement.
REQ-011 Port in_tag, input, TAG_W bits: destination tag for the operation.
REQ-012 Port out_valid, output, 1 bit: the result is available.
REQ-013 Port out_ready, input, 1 bit: the consumer takes the result.
REQ-014 Port result, output, WIDTH bits: product or quotient.
REQ-015 Port exception, output, 1 bit: overflow or divide-by-zero occurred.
REQ-016 Port out_tag, output, TAG_W bits: tag of the operation being returned.
REQ-017 Port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-018 The unit SHALL implement the states IDLE, MULT, DIV and DONE.
REQ-019 in_ready SHALL equal (state==IDLE) && !flush.
REQ-020 An accept SHALL occur on a rising edge where in_valid && in_ready; opA, opB, op and in_tag are captured on that edge.
REQ-021 On accept, the state SHALL go to MULT or DIV according to op, and the iteration counter SHALL load 0.
REQ-022 In MULT or DIV, the unit SHALL perform exactly one radix-2 iteration per cycle for WIDTH cycles, then enter DONE.
REQ-023 Latency: out_valid SHALL rise exactly WIDTH+1 edges after the accepting edge; for WIDTH=32 that is 33 edges.
REQ-024 In DONE, result, exception and out_tag SHALL be held stable until out_valid && out_ready; on that edge the state returns to IDLE.
REQ-025 The unit SHALL accept a new operation no earlier than the cycle after returning to IDLE; there is no accept in the same cycle as a result handshake.
REQ-026 Multiply SHALL set result to the low WIDTH bits of the signed product.
REQ-027 Multiply SHALL set exception=1 when the full 2*WIDTH-bit product is not the sign-extension of its low WIDTH bits.
REQ-028 Divide SHALL produce the signed quotient truncated toward zero; the remainder is discarded.
REQ-029 Divide with opB==0 SHALL give exception=1 and result=0, with normal latency.
REQ-030 Divide of the most-negative value by -1 SHALL give exception=1 and result equal to the most-negative value.
REQ-031 A flush in any state SHALL force IDLE on the next edge with out_valid=0, discarding the operation and any undelivered result.
REQ-032 Flush SHALL have priority over accept and over the result handshake in the same cycle.
REQ-033 In DONE, a cycle with flush=1 and out_ready=1 SHALL count as a discard, not a delivery.
REQ-034 out_valid SHALL be 0 in every state other than DONE.
REQ-035 Outside DONE, result, exception and out_tag SHALL be don't-care but SHALL NOT contain X after reset.

Reset
REQ-036 While reset is high on an edge, the state SHALL go to IDLE and the counter, result, exception, out_tag, out_valid and busy SHALL go to 0.
REQ-037 Reset asserted mid-operation SHALL abandon the operation with no output pulse; in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-038 Reset SHALL override flush and every handshake.

Structure
REQ-039 Shared package md_pkg SHALL hold the state enum and the op encoding constants OP_MULT=0 and OP_DIV=1.
REQ-040 A sub-module md_datapath SHALL hold the shift/add and non-restoring-subtract registers and the sign-correction logic, controlled by the FSM in md_unit.
REQ-041 The implementation SHALL contain no combinational path from in_valid to out_valid.

Verification
REQ-042 WIDTH=32, mult 7 * -3 with tag 9 -> out_valid exactly 33 edges after accept, result=-21, exception=0, out_tag=9.
REQ-043 Mult 0x40000000 * 4 -> result=0x00000000, exception=1; -7 div 2 -> result=-3, exception=0.
REQ-044 Div 5 by 0 -> result=0, exception=1; 0x80000000 div -1 -> result=0x80000000, exception=1.
REQ-045 Flush at iteration 10 of a divide -> busy=0 next cycle, no out_valid, next operation 6*6=36 correct.
REQ-046 out_ready held low 5 cycles in DONE -> result stable, in_ready=0 throughout; delivery on the first out_ready=1, then IDLE.
REQ-047 Reset at iteration 20 -> all outputs 0 next cycle, in_ready=1 after release, no spurious result.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the iterative signed multiply/divide unit:
// controller states and operation encodings.
package md_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/md_datapath.sv
// Magnitude-based shift/add multiplier and non-restoring divider with a final
// sign-correction step; sequenced by the controller in md_unit.
module md_datapath
   import md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic             finish,
   input  logic             op,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   output logic [WIDTH-1:0] result,
   output logic             exception
);

   localparam int W = WIDTH;

   logic [W+1:0]   acc_reg;
   logic [W-1:0]   shift_reg;
   logic [W-1:0]   opnd_reg;
   logic           op_reg;
   logic           neg_reg;
   logic           div_zero_reg;
   logic           div_ovf_reg;
   logic [W-1:0]   result_reg;
   logic           exception_reg;

   logic [W-1:0]   a_mag;
   logic [W-1:0]   b_mag;
   logic [W:0]     mul_sum;
   logic [W+1:0]   div_shift;
   logic [W+1:0]   div_new;
   logic [2*W-1:0] prod_mag;
   logic [2*W-1:0] prod;
   logic [W-1:0]   quot;
   logic           mul_ovf;

   always_comb begin
      a_mag     = opA[W-1] ? -opA : opA;
      b_mag     = opB[W-1] ? -opB : opB;
      mul_sum   = {1'b0, acc_reg[W-1:0]} + (shift_reg[0] ? {1'b0, opnd_reg} : '0);
      div_shift = {acc_reg[W:0], shift_reg[W-1]};
      // Non-restoring: add back the divisor when the partial remainder went negative
      div_new   = acc_reg[W+1] ? div_shift + {2'b00, opnd_reg}
                               : div_shift - {2'b00, opnd_reg};
      prod_mag  = {acc_reg[W-1:0], shift_reg};
      prod      = neg_reg ? -prod_mag : prod_mag;
      quot      = neg_reg ? -shift_reg : shift_reg;
      // Overflow unless the upper half plus the result sign bit are all equal
      mul_ovf   = !((&prod[2*W-1:W-1]) || !(|prod[2*W-1:W-1]));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         acc_reg       <= '0;
         shift_reg     <= '0;
         opnd_reg      <= '0;
         op_reg        <= OP_MULT;
         neg_reg       <= 1'b0;
         div_zero_reg  <= 1'b0;
         div_ovf_reg   <= 1'b0;
         result_reg    <= '0;
         exception_reg <= 1'b0;
      end else if (load) begin
         acc_reg      <= '0;
         op_reg       <= op;
         neg_reg      <= opA[W-1] ^ opB[W-1];
         opnd_reg     <= (op == OP_MULT) ? a_mag : b_mag;
         shift_reg    <= (op == OP_MULT) ? b_mag : a_mag;
         div_zero_reg <= (opB == '0);
         div_ovf_reg  <= (opA == {1'b1, {(W-1){1'b0}}}) && (opB == '1);
      end else if (step) begin
         if (op_reg == OP_MULT) begin
            acc_reg   <= {2'b00, mul_sum[W:1]};
            shift_reg <= {mul_sum[0], shift_reg[W-1:1]};
         end else begin
            acc_reg   <= div_new;
            shift_reg <= {shift_reg[W-2:0], ~div_new[W+1]};
         end
      end else if (finish) begin
         if (op_reg == OP_MULT) begin
            result_reg    <= prod[W-1:0];
            exception_reg <= mul_ovf;
         end else if (div_zero_reg) begin
            result_reg    <= '0;
            exception_reg <= 1'b1;
         end else begin
            result_reg    <= quot;
            exception_reg <= div_ovf_reg;
         end
      end
   end

   assign result    = result_reg;
   assign exception = exception_reg;

endmodule

// File: rtl/md_unit.sv
// Iterative signed multiply/divide unit with valid/ready handshakes, tag
// pass-through and flush; WIDTH iterations plus one sign-correction cycle.
module md_unit
   import md_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             exception,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   localparam int              CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [TAG_W-1:0]   tag_reg;
   logic               load;
   logic               step;
   logic               finish;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      load       = 1'b0;
      step       = 1'b0;
      finish     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               load       = 1'b1;
               cnt_next   = '0;
               state_next = (op == OP_DIV) ? DIV : MULT;
            end
         end
         MULT, DIV: begin
            // The pass after the last iteration applies signs and flags
            if (cnt_reg == CNT_LAST) begin
               finish     = 1'b1;
               state_next = DONE;
            end else begin
               step     = 1'b1;
               cnt_next = cnt_reg + 1'b1;
            end
         end
         DONE: begin
            if (out_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (flush) begin
         state_next = IDLE;
         load       = 1'b0;
         step       = 1'b0;
         finish     = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         tag_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (load)
            tag_reg <= in_tag;
      end
   end

   md_datapath #(.WIDTH(WIDTH)) u_datapath (
      .clock     (clock),
      .reset     (reset),
      .load      (load),
      .step      (step),
      .finish    (finish),
      .op        (op),
      .opA       (opA),
      .opB       (opB),
      .result    (result),
      .exception (exception)
   );

   assign in_ready  = (state_reg == IDLE) && !flush;
   assign out_valid = (state_reg == DONE);
   assign busy      = (state_reg != IDLE);
   assign out_tag   = tag_reg;

endmodule

// File: tb/tb_md_unit.sv
// Directed, table-driven bench for md_unit at WIDTH=32 plus hand-written
// sequences for result back-pressure, flush and mid-operation reset.
module tb_md_unit;

   localparam int WIDTH = 32;
   localparam int TAG_W = 5;

   logic             clock = 1'b0;
   logic             reset;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic             op;
   logic [WIDTH-1:0] opA;
   logic [WIDTH-1:0] opB;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             exception;
   logic [TAG_W-1:0] out_tag;
   logic             busy;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic             op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [TAG_W-1:0] tag;
      logic [WIDTH-1:0] res;
      logic             exc;
   } vec_t;

   vec_t vecs[13];

   always #5 clock = ~clock;

   md_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .opA       (opA),
      .opB       (opB),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .exception (exception),
      .out_tag   (out_tag),
      .busy      (busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Offer one operation, check latency and outputs, stall hold cycles, deliver.
   task automatic do_op(input vec_t v, input int hold);
      int edges;
      @(negedge clock);
      in_valid = 1'b1;
      op       = v.op;
      opA      = v.a;
      opB      = v.b;
      in_tag   = v.tag;
      #1 check("in_ready_idle", in_ready, 1);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      check("busy_after_accept", busy, 1);
      edges = 0;
      while (!out_valid && edges < 100) begin
         @(posedge clock);
         #1;
         edges++;
      end
      check("latency", edges, 33);
      check("result", result, v.res);
      check("exception", exception, v.exc);
      check("out_tag", out_tag, v.tag);
      for (int i = 0; i < hold; i++) begin
         @(posedge clock);
         #1;
         check("hold_result", result, v.res);
         check("hold_out_valid", out_valid, 1);
         check("hold_in_ready", in_ready, 0);
      end
      @(negedge clock);
      out_ready = 1'b1;
      @(posedge clock);
      #1;
      out_ready = 1'b0;
      check("out_valid_after_delivery", out_valid, 0);
      check("in_ready_after_delivery", in_ready, 1);
      $display("op=%0d a=0x%08h b=0x%08h tag=%0d -> result=0x%08h exc=%0d latency=%0d",
               v.op, v.a, v.b, v.tag, result, exception, edges);
   endtask

   initial begin
      int pulses;
      vec_t v;

      vecs[0]  = '{1'b0, 32'd7,         32'hFFFFFFFD, 5'd9,  32'hFFFFFFEB, 1'b0};
      vecs[1]  = '{1'b0, 32'h40000000,  32'd4,        5'd1,  32'h00000000, 1'b1};
      vecs[2]  = '{1'b1, 32'hFFFFFFF9,  32'd2,        5'd2,  32'hFFFFFFFD, 1'b0};
      vecs[3]  = '{1'b1, 32'd5,         32'd0,        5'd3,  32'h00000000, 1'b1};
      vecs[4]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF, 5'd4,  32'h80000000, 1'b1};
      vecs[5]  = '{1'b0, 32'hFFFFFFFB,  32'hFFFFFFFB, 5'd5,  32'd25,       1'b0};
      vecs[6]  = '{1'b1, 32'd100,       32'hFFFFFFF9, 5'd6,  32'hFFFFFFF2, 1'b0};
      vecs[7]  = '{1'b0, 32'h00010000,  32'h00008000, 5'd7,  32'h80000000, 1'b1};
      vecs[8]  = '{1'b0, 32'h80000000,  32'd1,        5'd8,  32'h80000000, 1'b0};
      vecs[9]  = '{1'b0, 32'h80000000,  32'hFFFFFFFF, 5'd10, 32'h80000000, 1'b1};
      vecs[10] = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF6, 5'd11, 32'd10,       1'b0};
      vecs[11] = '{1'b1, 32'd7,         32'd9,        5'd12, 32'd0,        1'b0};
      vecs[12] = '{1'b0, 32'h00012345,  32'h00000100, 5'd31, 32'h01234500, 1'b0};

      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      op        = 1'b0;
      opA       = '0;
      opB       = '0;
      in_tag    = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_busy", busy, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      check("rst_exception", exception, 0);
      check("rst_out_tag", out_tag, 0);
      @(negedge clock);
      reset = 1'b0;
      #1 check("rst_in_ready", in_ready, 1);

      for (int i = 0; i < 13; i++)
         do_op(vecs[i], 0);

      // Back-pressure: result held for 5 cycles before delivery
      v = '{1'b1, 32'd1000, 32'd3, 5'd17, 32'd333, 1'b0};
      do_op(v, 5);

      // Flush during iteration 10 of a divide
      @(negedge clock);
      in_valid = 1'b1;
      op       = 1'b1;
      opA      = 32'd1000;
      opB      = 32'd7;
      in_tag   = 5'd13;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clock);
      @(negedge clock);
      flush = 1'b1;
      #1 check("flush_in_ready", in_ready, 0);
      @(posedge clock);
      #1;
      flush = 1'b0;
      check("flush_busy", busy, 0);
      check("flush_out_valid", out_valid, 0);
      pulses = 0;
      repeat (40) begin
         @(posedge clock);
         #1;
         if (out_valid) pulses++;
      end
      check("flush_no_result", pulses, 0);
      $display("flush during divide: busy=%0d pulses=%0d", busy, pulses);
      v = '{1'b0, 32'd6, 32'd6, 5'd14, 32'd36, 1'b0};
      do_op(v, 0);

      // Reset during iteration 20 of a multiply
      @(negedge clock);
      in_valid = 1'b1;
      op       = 1'b0;
      opA      = 32'd1234;
      opB      = 32'd5678;
      in_tag   = 5'd21;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      repeat (20) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_result", result, 0);
      check("midrst_exception", exception, 0);
      check("midrst_out_tag", out_tag, 0);
      @(negedge clock);
      reset = 1'b0;
      #1 check("midrst_in_ready", in_ready, 1);
      pulses = 0;
      repeat (40) begin
         @(posedge clock);
         #1;
         if (out_valid) pulses++;
      end
      check("midrst_no_result", pulses, 0);
      $display("reset during multiply: busy=%0d pulses=%0d", busy, pulses);
      v = '{1'b0, 32'd1234, 32'd5678, 5'd21, 32'd7006652, 1'b0};
      do_op(v, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
